ad4008_spi_reader: RTL and testbench



---
 rtl/ad4008_spi_reader.sv | 123 ++++++++++++
 tb/tb_ad4008_spi_reader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ad4008_spi_reader.sv
// AD4008 3-wire SPI reader: CNV pulse, conversion wait, MSB-first capture on SCK, unsigned gain.
// Optional macro AD4008_READ_SATURATE_EN clamps the gained sample to all ones instead of wrapping.
module ad4008_spi_reader #(
    parameter int ADC_WIDTH    = 16,
    parameter int CONV_CYCLES  = 15,
    parameter int QUIET_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 data_in,
    output logic                 cnv,
    output logic                 sck,
    input  logic [15:0]          GAIN,
    output logic                 sresetn,
    output logic                 new_data_flag,
    output logic [ADC_WIDTH-1:0] amplified_data
);

    localparam int CNT_MAX = (CONV_CYCLES > 2*ADC_WIDTH) ? CONV_CYCLES : 2*ADC_WIDTH;
    localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACQ_LAST   = CNT_W'(2*ADC_WIDTH - 1);
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(QUIET_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        CONVERT,
        ACQUIRE,
        DONE,
        QUIET
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [ADC_WIDTH-1:0]   raw_data;
    logic [ADC_WIDTH-1:0]   gained;
    logic [1:0]             sync_ff;
    logic                   core_rst;

    // Assert asynchronously, release two clk edges after areset falls.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sync_ff <= 2'b00;
        end else begin
            sync_ff <= {sync_ff[0], 1'b1};
        end
    end

    assign sresetn  = sync_ff[1];
    assign core_rst = ~sresetn;

`ifdef AD4008_READ_SATURATE_EN
    logic [ADC_WIDTH+15:0] product;

    assign product = {16'b0, raw_data} * {{ADC_WIDTH{1'b0}}, GAIN};
    assign gained  = (|product[ADC_WIDTH+15:ADC_WIDTH]) ? '1 : product[ADC_WIDTH-1:0];
`else
    assign gained  = ADC_WIDTH'({16'b0, raw_data} * {{ADC_WIDTH{1'b0}}, GAIN});
`endif

    // One SCK period is two clk cycles; the sample is taken on the edge that raises SCK.
    always_ff @(posedge clk or posedge core_rst) begin
        if (core_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            cnv            <= 1'b0;
            sck            <= 1'b0;
            new_data_flag  <= 1'b0;
            amplified_data <= '0;
            raw_data       <= '0;
        end else begin
            new_data_flag <= 1'b0;
            case (state)
                IDLE: begin
                    state <= CONVERT;
                    cnv   <= 1'b1;
                    cnt   <= '0;
                end
                CONVERT: begin
                    if (cnt == CONV_LAST) begin
                        state <= ACQUIRE;
                        cnv   <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ACQUIRE: begin
                    sck <= ~sck;
                    if (!sck) begin
                        raw_data <= {raw_data[ADC_WIDTH-2:0], data_in};
                    end
                    if (cnt == ACQ_LAST) begin
                        state <= DONE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    amplified_data <= gained;
                    new_data_flag  <= 1'b1;
                    state          <= QUIET;
                    cnt            <= '0;
                end
                QUIET: begin
                    if (cnt == QUIET_LAST) begin
                        state <= CONVERT;
                        cnv   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad4008_spi_reader.sv
// Bench for ad4008_spi_reader: behavioural AD4008 model, frame timing measurement and gain reference.
// Expected gain results follow AD4008_READ_SATURATE_EN the same way the design build does.
module tb_ad4008_spi_reader;

    logic        clk;
    logic        areset;
    logic        data_in;
    logic        cnv;
    logic        sck;
    logic [15:0] GAIN;
    logic        sresetn;
    logic        new_data_flag;
    logic [15:0] amplified_data;

    int          checks;
    int          failures;
    logic [15:0] model_word;
    logic [15:0] cur_word;
    logic [15:0] last_exp;
    logic [15:0] lat_word;
    int          bit_pos;

    ad4008_spi_reader dut (
        .clk            (clk),
        .areset         (areset),
        .data_in        (data_in),
        .cnv            (cnv),
        .sck            (sck),
        .GAIN           (GAIN),
        .sresetn        (sresetn),
        .new_data_flag  (new_data_flag),
        .amplified_data (amplified_data)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // ADC model: word latched at CNV rise, MSB driven on CNV fall, next bit on each SCK fall.
    initial begin
        data_in  = 1'b0;
        lat_word = 16'h0000;
        bit_pos  = 0;
    end

    always @(posedge cnv or negedge cnv or negedge sck) begin
        if (cnv) begin
            lat_word = model_word;
            bit_pos  = 0;
        end else begin
            data_in <= #2 (bit_pos < 16) ? lat_word[15 - bit_pos] : 1'b0;
            bit_pos  = bit_pos + 1;
        end
    end

    function automatic logic [15:0] expectedGain(input logic [15:0] w, input logic [15:0] g);
        logic [63:0] p;
        p = 64'(w) * 64'(g);
`ifdef AD4008_READ_SATURATE_EN
        return (p >= 64'd65536) ? 16'hFFFF : p[15:0];
`else
        return p[15:0];
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] gain, input logic [15:0] next_word);
        GAIN       = gain;
        model_word = next_word;
    endtask

    task automatic waitCnvRise(output int waited);
        logic p;
        logic rose;
        waited = 0;
        rose   = 1'b0;
        p      = cnv;
        do begin
            @(negedge clk);
            waited++;
            rose = cnv && !p;
            p    = cnv;
        end while (!rose && waited < 200);
    endtask

    // Called on the first negedge with cnv high; observes the whole 50-cycle frame.
    task automatic measureFrame(input logic [15:0] gain, input logic [15:0] next_word);
        logic [15:0] word;
        logic [15:0] exp_amp;
        logic [15:0] amp;
        logic        psck;
        int          cnv_hi;
        int          rises;
        int          viol;
        int          flag_cnt;
        int          flag_t;
        word     = cur_word;
        exp_amp  = expectedGain(word, gain);
        applyStimulus(gain, next_word);
        cur_word = next_word;
        psck     = 1'b0;
        cnv_hi   = 0;
        rises    = 0;
        viol     = 0;
        flag_cnt = 0;
        flag_t   = -1;
        amp      = 16'h0000;
        for (int t = 0; t < 50; t++) begin
            if (t > 0) @(negedge clk);
            if (cnv) cnv_hi++;
            if (sck && !psck) rises++;
            psck = sck;
            if (cnv && sck) viol++;
            if (new_data_flag) begin
                if (flag_cnt == 0) begin
                    flag_t = t;
                    amp    = amplified_data;
                end
                flag_cnt++;
            end
        end
        checkOutput("cnv_width", cnv_hi, 15);
        checkOutput("sck_pulses", rises, 16);
        checkOutput("sck_during_cnv", viol, 0);
        checkOutput("flag_latency", flag_t, 48);
        checkOutput("flag_width", flag_cnt, 1);
        checkOutput("amplified_data", amp, exp_amp);
        last_exp = exp_amp;
    endtask

    task automatic runFrame(input logic [15:0] gain, input logic [15:0] next_word);
        int waited;
        waitCnvRise(waited);
        checkOutput("frame_period", waited, 1);
        measureFrame(gain, next_word);
    endtask

    initial begin
        int waited;
        checks     = 0;
        failures   = 0;
        areset     = 1'b1;
        GAIN       = 16'h0000;
        model_word = 16'hAAAA;
        cur_word   = 16'hAAAA;
        last_exp   = 16'h0000;

        repeat (3) @(negedge clk);
        checkOutput("reset_sresetn", sresetn, 0);
        checkOutput("reset_cnv", cnv, 0);
        checkOutput("reset_sck", sck, 0);
        checkOutput("reset_flag", new_data_flag, 0);
        checkOutput("reset_amp", amplified_data, 0);

        areset = 1'b0;
        @(negedge clk);
        checkOutput("sync_edge1", sresetn, 0);
        @(negedge clk);
        checkOutput("sync_edge2", sresetn, 1);
        checkOutput("idle_cnv", cnv, 0);
        @(negedge clk);
        checkOutput("cnv_after_idle", cnv, 1);

        measureFrame(16'd2, 16'h00F0);
        runFrame(16'd2, 16'h1234);
        runFrame(16'd1, 16'h1234);
        runFrame(16'd0, 16'($urandom));
        for (int i = 0; i < 4; i++) begin
            logic [15:0] g;
            g = (i % 2 == 1) ? 16'($urandom_range(0, 3)) : 16'($urandom);
            runFrame(g, (i == 3) ? 16'h1234 : 16'($urandom));
        end
        runFrame(16'd3, 16'($urandom));

        // Reset asserted while SCK is high in the middle of ACQUIRE.
        waitCnvRise(waited);
        checkOutput("frame_period", waited, 1);
        repeat (26) @(negedge clk);
        checkOutput("amp_hold", amplified_data, last_exp);
        checkOutput("sck_before_reset", sck, 1);
        model_word = 16'h0F0F;
        cur_word   = 16'h0F0F;
        areset     = 1'b1;
        #1;
        checkOutput("midframe_sresetn", sresetn, 0);
        checkOutput("midframe_cnv", cnv, 0);
        checkOutput("midframe_sck", sck, 0);
        checkOutput("midframe_flag", new_data_flag, 0);
        checkOutput("midframe_amp", amplified_data, 0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        @(negedge clk);
        checkOutput("resync_edge1", sresetn, 0);
        @(negedge clk);
        checkOutput("resync_edge2", sresetn, 1);
        checkOutput("reidle_cnv", cnv, 0);
        @(negedge clk);
        checkOutput("recnv_rise", cnv, 1);
        measureFrame(16'd5, 16'h8001);
        runFrame(16'hFFFF, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
